// File: rtl/sync_hs_pkg.sv
// Shared types and sizing helpers for the handshake-synchronizer source front end.
package sync_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } hs_state_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_PTR_W      = ptr_width(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers and registered full/empty/level.
module sync_fifo
    import sync_hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W     = ptr_width(DEPTH),
    localparam int IDX_W     = PTR_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [PTR_W-1:0]      level_q, level_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign wr_fire = wr_en && !full_q;
    assign rd_fire = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Flags are precomputed from the next pointers so they come straight off flops.
        full_d  = (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]) &&
                  (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/sync_hs_feeder.sv
// Source-domain front end: queues producer words and launches one synchronizer transfer at a time.
module sync_hs_feeder
    import sync_hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk_source,
    input  logic                          rst_source,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    input  logic                          sync_busy,
    output logic                          sig_pulse_source,
    output logic [DATA_WIDTH-1:0]         sig_data_source,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);

    hs_state_e             state_q, state_d;
    logic                  pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [PTR_W-1:0]      fifo_lvl;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_source),
        .rst     (rst_source),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    always_comb begin
        state_d    = state_q;
        pulse_d    = 1'b0;
        data_d     = data_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (in_valid & fifo_full);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !sync_busy) begin
                    state_d = ST_LAUNCH;
                    pop     = 1'b1;
                    pulse_d = 1'b1;
                    data_d  = fifo_rd_data;
                end
            end
            // Busy is not yet visible here: the synchronizer only registers the pulse at this edge.
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!sync_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_source or posedge rst_source) begin
        if (rst_source) begin
            state_q    <= ST_IDLE;
            pulse_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready         = !fifo_full;
    assign sig_pulse_source = pulse_q;
    assign sig_data_source  = data_q;
    assign fifo_level       = fifo_lvl;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_sync_hs_feeder.sv
// Bench for sync_hs_feeder: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_sync_hs_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_source = 1'b0;
    logic          rst_source = 1'b1;
    logic          in_valid   = 1'b0;
    logic [DW-1:0] in_data    = '0;
    logic          in_ready;
    logic          sync_busy  = 1'b0;
    logic          sig_pulse_source;
    logic [DW-1:0] sig_data_source;
    logic [2:0]    fifo_level;
    logic          overflow;

    sync_hs_feeder #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_source       (clk_source),
        .rst_source       (rst_source),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .sync_busy        (sync_busy),
        .sig_pulse_source (sig_pulse_source),
        .sig_data_source  (sig_data_source),
        .fifo_level       (fifo_level),
        .overflow         (overflow)
    );

    always #5 clk_source = ~clk_source;

    int n_checks = 0;
    int n_fail   = 0;

    // Synchronizer stand-in: busy rises the cycle after it sees the pulse, lasts busy_len cycles.
    int   busy_mode = 0;
    int   busy_cnt  = 0;
    int   busy_len  = 5;
    logic pulse_prev = 1'b0;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] din;
        logic          busy;
        logic          exp_pulse;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_level;
        logic          exp_ready;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_source);
        #1;
        if (pulse_prev) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        pulse_prev = sig_pulse_source;
        if (busy_mode == 1) sync_busy = (busy_cnt != 0);
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_data    = '0;
        sync_busy  = 1'b0;
        busy_mode  = 0;
        busy_cnt   = 0;
        pulse_prev = 1'b0;
        @(negedge clk_source);
        rst_source = 1'b1;
        @(negedge clk_source);
        rst_source = 1'b0;
    endtask

    task automatic drain(input int cycles, input logic [DW-1:0] first, input int expect_n, input string tag);
        int n = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (sig_pulse_source) begin
                check({tag, "_data"}, sig_data_source, first + n[DW-1:0]);
                n++;
            end
        end
        check({tag, "_count"}, n, expect_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            vld   din    busy  pulse data   lvl   rdy   ovf
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 8'h3C, 3'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 3'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 3'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 3'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 3'd0, 1'b1, 1'b0};

        // Reset values
        #12;
        check("rst_pulse", sig_pulse_source, 0);
        check("rst_data", sig_data_source, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_ovf", overflow, 0);
        @(negedge clk_source);
        rst_source = 1'b0;

        // Vector table: one row per clock edge
        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].din;
            sync_busy = vecs[i].busy;
            step();
            check($sformatf("vec%0d_pulse", i), sig_pulse_source, vecs[i].exp_pulse);
            check($sformatf("vec%0d_data", i), sig_data_source, vecs[i].exp_data);
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            $display("vec %0d: pulse=%0d data=%02h level=%0d", i, sig_pulse_source, sig_data_source, fifo_level);
        end

        // Full and overflow with busy held high
        do_reset();
        sync_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + k[7:0];
            step();
            check($sformatf("full_level%0d", k), fifo_level, (k < 4) ? k + 1 : 4);
            check($sformatf("full_ready%0d", k), in_ready, (k < 3) ? 1 : 0);
            check($sformatf("full_ovf%0d", k), overflow, (k == 4) ? 1 : 0);
            check($sformatf("full_nopulse%0d", k), sig_pulse_source, 0);
            $display("full write %0d: level=%0d ready=%0d ovf=%0d", k, fifo_level, in_ready, overflow);
        end
        in_valid = 1'b0;
        step();
        check("ovf_sticky", overflow, 1);
        busy_mode = 1;
        sync_busy = 1'b0;
        drain(50, 8'h10, 4, "full_drain");
        check("ovf_after_drain", overflow, 1);
        check("level_after_drain", fifo_level, 0);

        // Write on the launch edge at level 2
        do_reset();
        sync_busy = 1'b1;
        in_valid = 1'b1; in_data = 8'h20; step();
        in_valid = 1'b1; in_data = 8'h21; step();
        check("sim_pre_level", fifo_level, 2);
        in_valid = 1'b1; in_data = 8'h22; sync_busy = 1'b0;
        step();
        in_valid = 1'b0;
        check("sim_pulse", sig_pulse_source, 1);
        check("sim_data", sig_data_source, 8'h20);
        check("sim_level", fifo_level, 2);
        $display("simultaneous write/pop: level=%0d data=%02h", fifo_level, sig_data_source);
        busy_mode = 1;
        drain(40, 8'h21, 2, "sim_drain");

        // Asynchronous reset while waiting on the synchronizer
        do_reset();
        sync_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'h40 + k[7:0]; step();
        end
        in_valid = 1'b0;
        busy_mode = 1;
        sync_busy = 1'b0;
        step();
        check("rw_launch", sig_pulse_source, 1);
        step();
        check("rw_level", fifo_level, 3);
        check("rw_data", sig_data_source, 8'h40);
        check("rw_busy_seen", sync_busy, 1);
        @(negedge clk_source);
        #2;
        rst_source = 1'b1;
        #1;
        check("rw_pulse", sig_pulse_source, 0);
        check("rw_rdata", sig_data_source, 0);
        check("rw_rlevel", fifo_level, 0);
        check("rw_ready", in_ready, 1);
        check("rw_ovf", overflow, 0);
        $display("async reset in WAIT: level=%0d ovf=%0d", fifo_level, overflow);
        @(negedge clk_source);
        rst_source = 1'b0;
        busy_mode = 0; busy_cnt = 0; pulse_prev = 1'b0; sync_busy = 1'b0;
        drain(10, 8'h00, 0, "rw_quiet");
        in_valid = 1'b1; in_data = 8'h55; step();
        in_valid = 1'b0; step();
        check("rw_new_pulse", sig_pulse_source, 1);
        check("rw_new_data", sig_data_source, 8'h55);

        // Random traffic against a queue model
        begin
            logic [DW-1:0] q[$];
            logic [DW-1:0] last_data;
            logic          m_ovf;
            logic          last_pulse;
            int            stall;
            int            pre_size;
            logic          pre_valid;
            logic [DW-1:0] pre_data;
            logic          pre_busy;
            logic [DW-1:0] exp_word;
            int            n_launch;

            do_reset();
            busy_mode  = 1;
            last_data  = '0;
            m_ovf      = 1'b0;
            last_pulse = 1'b0;
            stall      = 0;
            n_launch   = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                busy_len = $urandom_range(1, 5);
                in_valid = ($urandom_range(0, 9) < 6);
                in_data  = DW'($urandom);
                pre_size  = q.size();
                pre_valid = in_valid;
                pre_data  = in_data;
                pre_busy  = sync_busy;
                step();
                if (pre_valid && pre_size < DEPTH) q.push_back(pre_data);
                if (pre_valid && pre_size >= DEPTH) m_ovf = 1'b1;
                if (sig_pulse_source) begin
                    check("rnd_launch_nonempty", (pre_size != 0), 1);
                    check("rnd_launch_not_busy", pre_busy, 0);
                    check("rnd_no_back_to_back", last_pulse, 0);
                    exp_word = (q.size() != 0) ? q.pop_front() : '0;
                    check("rnd_data", sig_data_source, exp_word);
                    last_data = exp_word;
                    n_launch++;
                    $display("rnd launch %0d: data=%02h level=%0d", n_launch, sig_data_source, fifo_level);
                end else begin
                    check("rnd_data_hold", sig_data_source, last_data);
                end
                check("rnd_level", fifo_level, q.size());
                check("rnd_ready", in_ready, (q.size() < DEPTH) ? 1 : 0);
                check("rnd_ovf", overflow, m_ovf);
                last_pulse = sig_pulse_source;
                if (pre_size > 0 && !sig_pulse_source) stall++;
                else stall = 0;
                check("rnd_progress", (stall <= 12), 1);
            end
            in_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_hs_feeder.md
# sync_hs_feeder

Source-domain front end for the multi-bit handshake synchronizer. It buffers words from a valid/ready producer in a small FIFO and launches one transfer at a time to the synchronizer. Each transfer is a single-cycle `sig_pulse_source` with stable `sig_data_source`, issued only when the synchronizer's `sync_busy` allows it. It sits entirely in the source clock domain, between the producer and the synchronizer's source-side ports.

## Interface
- `DATA_WIDTH`, 8: word width; must match the synchronizer.
- `FIFO_DEPTH`, 4: entries; power of two, ≥2.
- `clk_source`  in  1: source-domain clock.
- `rst_source`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: producer word valid.
- `in_data`  in  DATA_WIDTH: producer word.
- `in_ready`  out  1: FIFO not full; a write occurs when `in_valid && in_ready`.
- `sync_busy`  in  1: busy flag from the synchronizer.
- `sig_pulse_source`  out  1: one-cycle launch pulse to the synchronizer.
- `sig_data_source`  out  DATA_WIDTH: word being launched; registered.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky; set when `in_valid && !in_ready`. Cleared only by reset.

## Operation
- FIFO behaviour:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Full when the indices are equal and the MSBs differ; empty when the pointers are equal.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- `in_ready = !full`, decoded from registered pointers. A write and a pop in the same cycle are both honoured, and `fifo_level` is unchanged. A write while full is dropped and sets `overflow`.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH when `!empty && !sync_busy`. At that edge: pop the head, load it into `sig_data_source`, set `sig_pulse_source`=1.
  - LAUNCH → WAIT unconditionally. `sig_pulse_source` returns to 0. The synchronizer registers the pulse, so `sync_busy` is high from the first WAIT cycle.
  - WAIT → IDLE when `sync_busy`=0. Otherwise stay in WAIT.
  - `sync_busy` high while in IDLE just holds IDLE; it is not an error.
- `sig_data_source` holds its value from the launch edge until the next launch and never changes in between.
- There is no write-to-launch bypass: a word written into an empty FIFO is launched at the earliest on the following edge.

## Timing
- Reset values: state IDLE, pointers 0, `sig_pulse_source`=0, `sig_data_source`=0, `fifo_level`=0, `overflow`=0, `in_ready`=1.
- Latency, idle block with `sync_busy`=0:
  - Write accepted at edge E0.
  - Pulse is high during the cycle after E1, with data valid in that same cycle.
- Launch spacing: at most one pulse per handshake. The next pulse comes no earlier than 1 cycle after `sync_busy` is observed low, which is the IDLE evaluation edge.
- `sig_pulse_source` is never high in two consecutive cycles.
- Reset mid-handshake: all state clears asynchronously and queued words are lost. The synchronizer, reset on the same `rst_source`, also returns to idle.

## Structure
- Package `sync_hs_pkg`: FSM state enum (IDLE/LAUNCH/WAIT) and the pointer-width function/constant derived from FIFO_DEPTH.
- Sub-module `sync_fifo`: single-clock FIFO with registered full/empty and level. `sync_hs_feeder` instantiates it and adds the FSM and output registers.

## Test plan
- Single word: reset, write 0xA5 with `sync_busy`=0 → pulse 2 cycles after the write edge, `sig_data_source`=0xA5. Model `sync_busy` high 6 cycles later → no second pulse; back to IDLE after busy falls.
- Burst: write 0x01..0x04 back-to-back, busy model high for 5 cycles per transfer → exactly 4 pulses in order 0x01..0x04, `fifo_level` peaks at 3, `sig_data_source` stable between pulses.
- Full/overflow: hold `sync_busy`=1, write 5 words → `in_ready`=0 after 4, 5th dropped, `overflow`=1 and stays 1. Release busy → 4 pulses only.
- Simultaneous write and pop: level 2, write on the launch edge → level stays 2, order preserved.
- Reset in WAIT: assert `rst_source` asynchronously mid-clock → outputs go to reset values immediately, and no pulse follows release until a new write.
- End-to-end: instantiate with the synchronizer (source 50 MHz, dest 133 MHz and 20 MHz), random words → destination data sequence equals the written sequence, no loss.
